// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: response codes, channel FSM states and default-width command entry layouts
// shared by the queued AXI4-Lite master and its bench.
package axi4_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} rd_state_e;
  typedef struct packed {
    logic [CMD_ADDR_W-1:0]   addr;
    logic [CMD_DATA_W-1:0]   data;
    logic [CMD_DATA_W/8-1:0] strb;
    logic [2:0]              prot;
  } wr_cmd_t;
  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [2:0]            prot;
  } rd_cmd_t;
endpackage

// File: rtl/axi4_lite_cmd_fifo.sv
// axi4_lite_cmd_fifo: synchronous FIFO with full/empty flags; DEPTH must be a power of 2.
module axi4_lite_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0] wp_q, rp_q;
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign dout_o  = mem_q[rp_q[PW-1:0]];
  assign empty_o = wp_q == rp_q;
  assign full_o  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + (PW+1)'(1);
      if (pop_i) rp_q <= rp_q + (PW+1)'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wp_q[PW-1:0]] <= din_i;
  end
endmodule

// File: rtl/axi4_lite_master_q.sv
// axi4_lite_master_q: queued AXI4-Lite master; independent read/write channels, each with a
// command FIFO, one outstanding transaction and a watchdog that forces a SLVERR response.
module axi4_lite_master_q
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                wr_cmd_valid,
  output logic                wr_cmd_ready,
  input  logic [ADDR_W-1:0]   wr_cmd_addr,
  input  logic [DATA_W-1:0]   wr_cmd_data,
  input  logic [DATA_W/8-1:0] wr_cmd_strb,
  input  logic [2:0]          wr_cmd_prot,
  input  logic                rd_cmd_valid,
  output logic                rd_cmd_ready,
  input  logic [ADDR_W-1:0]   rd_cmd_addr,
  input  logic [2:0]          rd_cmd_prot,
  output logic                wr_rsp_valid,
  output logic [1:0]          wr_rsp_resp,
  output logic                wr_rsp_timeout,
  output logic                rd_rsp_valid,
  output logic [DATA_W-1:0]   rd_rsp_data,
  output logic [1:0]          rd_rsp_resp,
  output logic                rd_rsp_timeout,
  output logic                wr_busy,
  output logic                rd_busy,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP
);
  // Same layout as the package entries, sized to this instance.
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic [2:0]          prot;
  } wr_ent_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        prot;
  } rd_ent_t;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = TIMEOUT > 0;
  wr_ent_t wf_din, wf_dout, wcmd_q, wcmd_d;
  rd_ent_t rf_din, rf_dout, rcmd_q, rcmd_d;
  logic wf_full, wf_empty, wf_pop, rf_full, rf_empty, rf_pop;
  wr_state_e ws_q, ws_d;
  rd_state_e rs_q, rs_d;
  logic aw_vld_q, aw_vld_d, w_vld_q, w_vld_d, wab_q, wab_d, rab_q, rab_d;
  logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic wv_q, wv_d, wt_q, wt_d, rv_q, rv_d, rt_q, rt_d;
  logic [1:0] wr_q, wr_d, rr_q, rr_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  assign wf_din = {wr_cmd_addr, wr_cmd_data, wr_cmd_strb, wr_cmd_prot};
  assign rf_din = {rd_cmd_addr, rd_cmd_prot};
  assign wr_cmd_ready = !wf_full;
  assign rd_cmd_ready = !rf_full;
  axi4_lite_cmd_fifo #(.WIDTH($bits(wr_ent_t)), .DEPTH(CMD_DEPTH)) u_wr_fifo (
    .clk_i(ACLK), .rst_ni(ARESETn), .push_i(wr_cmd_valid && !wf_full), .pop_i(wf_pop),
    .din_i(wf_din), .dout_o(wf_dout), .full_o(wf_full), .empty_o(wf_empty));
  axi4_lite_cmd_fifo #(.WIDTH($bits(rd_ent_t)), .DEPTH(CMD_DEPTH)) u_rd_fifo (
    .clk_i(ACLK), .rst_ni(ARESETn), .push_i(rd_cmd_valid && !rf_full), .pop_i(rf_pop),
    .din_i(rf_din), .dout_o(rf_dout), .full_o(rf_full), .empty_o(rf_empty));
  assign AWVALID = aw_vld_q;
  assign AWADDR  = wcmd_q.addr;
  assign AWPROT  = wcmd_q.prot;
  assign WVALID  = w_vld_q;
  assign WDATA   = wcmd_q.data;
  assign WSTRB   = wcmd_q.strb;
  assign BREADY  = ws_q == W_RESP;
  assign ARVALID = rs_q == R_ISSUE;
  assign ARADDR  = rcmd_q.addr;
  assign ARPROT  = rcmd_q.prot;
  assign RREADY  = rs_q == R_RESP;
  assign wr_rsp_valid   = wv_q;
  assign wr_rsp_resp    = wr_q;
  assign wr_rsp_timeout = wt_q;
  assign rd_rsp_valid   = rv_q;
  assign rd_rsp_data    = rdat_q;
  assign rd_rsp_resp    = rr_q;
  assign rd_rsp_timeout = rt_q;
  assign wr_busy = !wf_empty || ws_q != W_IDLE;
  assign rd_busy = !rf_empty || rs_q != R_IDLE;
  always_comb begin
    ws_d = ws_q;
    wcmd_d = wcmd_q;
    aw_vld_d = aw_vld_q;
    w_vld_d = w_vld_q;
    wcnt_d = wcnt_q;
    wab_d = wab_q;
    wf_pop = 1'b0;
    wv_d = 1'b0;
    wt_d = 1'b0;
    wr_d = wr_q;
    unique case (ws_q)
      W_IDLE: if (!wf_empty) begin
        wf_pop = 1'b1;
        wcmd_d = wf_dout;
        aw_vld_d = 1'b1;
        w_vld_d = 1'b1;
        wcnt_d = '0;
        wab_d = 1'b0;
        ws_d = W_ISSUE;
      end
      W_ISSUE: begin
        aw_vld_d = aw_vld_q && !AWREADY;
        w_vld_d = w_vld_q && !WREADY;
        if (!aw_vld_d && !w_vld_d) ws_d = W_RESP;
      end
      W_RESP: if (BVALID) begin
        ws_d = W_IDLE;
        wv_d = !wab_q;
        wr_d = wab_q ? wr_q : BRESP;
      end
      default: ws_d = W_IDLE;
    endcase
    // A handshake in the expiry cycle completes normally, so the real response wins.
    if (WD_EN && ws_q != W_IDLE && !wab_q && !(ws_q == W_RESP && BVALID)) begin
      wcnt_d = wcnt_q + CW'(1);
      if (wcnt_q == TO_LAST) begin
        wab_d = 1'b1;
        wv_d = 1'b1;
        wt_d = 1'b1;
        wr_d = RESP_SLVERR;
      end
    end
  end
  always_comb begin
    rs_d = rs_q;
    rcmd_d = rcmd_q;
    rcnt_d = rcnt_q;
    rab_d = rab_q;
    rf_pop = 1'b0;
    rv_d = 1'b0;
    rt_d = 1'b0;
    rr_d = rr_q;
    rdat_d = rdat_q;
    unique case (rs_q)
      R_IDLE: if (!rf_empty) begin
        rf_pop = 1'b1;
        rcmd_d = rf_dout;
        rcnt_d = '0;
        rab_d = 1'b0;
        rs_d = R_ISSUE;
      end
      R_ISSUE: if (ARREADY) rs_d = R_RESP;
      R_RESP: if (RVALID) begin
        rs_d = R_IDLE;
        rv_d = !rab_q;
        rr_d = rab_q ? rr_q : RRESP;
        rdat_d = rab_q ? rdat_q : RDATA;
      end
      default: rs_d = R_IDLE;
    endcase
    if (WD_EN && rs_q != R_IDLE && !rab_q && !(rs_q == R_RESP && RVALID)) begin
      rcnt_d = rcnt_q + CW'(1);
      if (rcnt_q == TO_LAST) begin
        rab_d = 1'b1;
        rv_d = 1'b1;
        rt_d = 1'b1;
        rr_d = RESP_SLVERR;
        rdat_d = '0;
      end
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ws_q <= W_IDLE;
      rs_q <= R_IDLE;
      wcmd_q <= '0;
      rcmd_q <= '0;
      aw_vld_q <= 1'b0;
      w_vld_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      wab_q <= 1'b0;
      rab_q <= 1'b0;
      wv_q <= 1'b0;
      wt_q <= 1'b0;
      wr_q <= '0;
      rv_q <= 1'b0;
      rt_q <= 1'b0;
      rr_q <= '0;
      rdat_q <= '0;
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
      wcmd_q <= wcmd_d;
      rcmd_q <= rcmd_d;
      aw_vld_q <= aw_vld_d;
      w_vld_q <= w_vld_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wab_q <= wab_d;
      rab_q <= rab_d;
      wv_q <= wv_d;
      wt_q <= wt_d;
      wr_q <= wr_d;
      rv_q <= rv_d;
      rt_q <= rt_d;
      rr_q <= rr_d;
      rdat_q <= rdat_d;
    end
  end
endmodule

// File: tb/tb_axi4_lite_master_q.sv
// tb_axi4_lite_master_q: directed stimulus against a configurable slave; expected responses
// are queued at issue time and matched by an independent response monitor.
module tb_axi4_lite_master_q;
  import axi4_lite_pkg::*;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;
  logic wr_cmd_valid, wr_cmd_ready, rd_cmd_valid, rd_cmd_ready;
  logic [31:0] wr_cmd_addr, wr_cmd_data, rd_cmd_addr;
  logic [3:0] wr_cmd_strb;
  logic [2:0] wr_cmd_prot, rd_cmd_prot;
  logic wr_rsp_valid, wr_rsp_timeout, rd_rsp_valid, rd_rsp_timeout, wr_busy, rd_busy;
  logic [1:0] wr_rsp_resp, rd_rsp_resp;
  logic [31:0] rd_rsp_data;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0] AWPROT, ARPROT;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  axi4_lite_master_q #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_data(wr_cmd_data), .wr_cmd_strb(wr_cmd_strb), .wr_cmd_prot(wr_cmd_prot),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_prot(rd_cmd_prot),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_resp(wr_rsp_resp), .wr_rsp_timeout(wr_rsp_timeout),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_resp(rd_rsp_resp),
    .rd_rsp_timeout(rd_rsp_timeout), .wr_busy(wr_busy), .rd_busy(rd_busy),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP));

  int total = 0;
  int bad = 0;
  typedef struct packed {logic [1:0] resp; logic to;} wexp_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic to;} rexp_t;
  wexp_t exp_wr[$];
  rexp_t exp_rd[$];
  wexp_t mw;
  rexp_t mr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Slave behaviour knobs, changed by the stimulus between tests.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit b_en = 1'b1, r_force = 1'b0;
  logic [1:0] b_resp = RESP_OKAY, r_resp = RESP_OKAY;
  logic [31:0] r_force_data = '0;

  initial begin
    int awc, wc, bc, arc, rc;
    bit aw_got, w_got, ar_got, awf, wf, bf, arf, rf;
    logic [31:0] ar_a;
    {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
    BRESP = '0; RRESP = '0; RDATA = '0;
    {awc, wc, bc, arc, rc} = '0;
    {aw_got, w_got, ar_got, awf, wf, bf, arf, rf} = '0;
    ar_a = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
        {awc, wc, bc, arc, rc} = '0;
        {aw_got, w_got, ar_got, awf, wf, bf, arf, rf} = '0;
      end else begin
        if (awf) begin aw_got = 1; awc = 0; end
        if (wf) begin w_got = 1; wc = 0; end
        if (arf) begin ar_got = 1; arc = 0; end
        if (bf) begin BVALID = 0; aw_got = 0; w_got = 0; bc = 0; end
        if (rf) begin RVALID = 0; ar_got = 0; rc = 0; end
        if (aw_got && w_got && !BVALID && b_en) begin
          if (bc >= b_dly) begin BVALID = 1; BRESP = b_resp; end else bc++;
        end
        if (ar_got && !RVALID) begin
          if (rc >= r_dly) begin
            RVALID = 1;
            RRESP = r_resp;
            RDATA = r_force ? r_force_data : (32'hA000_0000 | ar_a);
          end else rc++;
        end
        AWREADY = AWVALID && !aw_got && awc >= aw_dly;
        if (AWVALID && !aw_got && !AWREADY) awc++;
        WREADY = WVALID && !w_got && wc >= w_dly;
        if (WVALID && !w_got && !WREADY) wc++;
        ARREADY = ARVALID && !ar_got && arc >= ar_dly;
        if (ARVALID && !ar_got && !ARREADY) arc++;
        awf = AWVALID && AWREADY;
        wf = WVALID && WREADY;
        arf = ARVALID && ARREADY;
        if (arf) ar_a = ARADDR;
        bf = BVALID && BREADY;
        rf = RVALID && RREADY;
      end
    end
  end

  initial begin
    forever begin
      @(negedge ACLK);
      if (wr_rsp_valid) begin
        chk("wr_rsp_pending", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          mw = exp_wr.pop_front();
          chk("wr_rsp_resp", wr_rsp_resp, mw.resp);
          chk("wr_rsp_timeout", wr_rsp_timeout, mw.to);
        end
      end
      if (rd_rsp_valid) begin
        chk("rd_rsp_pending", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          mr = exp_rd.pop_front();
          chk("rd_rsp_data", rd_rsp_data, mr.data);
          chk("rd_rsp_resp", rd_rsp_resp, mr.resp);
          chk("rd_rsp_timeout", rd_rsp_timeout, mr.to);
        end
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] p);
    wr_cmd_valid = 1; wr_cmd_addr = a; wr_cmd_data = d; wr_cmd_strb = s; wr_cmd_prot = p;
    @(negedge ACLK);
    wr_cmd_valid = 0;
  endtask

  task automatic push_rd(input logic [31:0] a);
    rd_cmd_valid = 1; rd_cmd_addr = a; rd_cmd_prot = 3'b001;
    @(negedge ACLK);
    rd_cmd_valid = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((wr_busy || rd_busy || exp_wr.size() != 0 || exp_rd.size() != 0) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    chk({nm, "_idle"}, n < 200, 1);
    repeat (3) @(negedge ACLK);
  endtask

  task automatic wait_aw(input string nm);
    int n = 0;
    while (!AWVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk({nm, "_awvalid"}, AWVALID, 1);
  endtask

  initial begin
    int cyc;
    logic [31:0] rexp [4];
    rexp[0] = 32'hA000_0000; rexp[1] = 32'hA000_0004;
    rexp[2] = 32'hA000_0008; rexp[3] = 32'hA000_000C;
    wr_cmd_valid = 0; wr_cmd_addr = '0; wr_cmd_data = '0; wr_cmd_strb = '0; wr_cmd_prot = '0;
    rd_cmd_valid = 0; rd_cmd_addr = '0; rd_cmd_prot = '0;
    repeat (2) @(negedge ACLK);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_rsp_valid", {wr_rsp_valid, rd_rsp_valid}, 0);
    chk("rst_busy", {wr_busy, rd_busy}, 0);
    chk("rst_cmd_ready", {wr_cmd_ready, rd_cmd_ready}, 2'b11);
    ARESETn = 1;
    @(negedge ACLK);

    // Single write, W accepted three cycles after AW.
    aw_dly = 0; w_dly = 3;
    exp_wr.push_back('{RESP_OKAY, 1'b0});
    chk("t1_wr_ready", wr_cmd_ready, 1);
    push_wr(32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010);
    wait_aw("t1");
    chk("t1_wvalid", WVALID, 1);
    chk("t1_awaddr", AWADDR, 32'h10);
    chk("t1_awprot", AWPROT, 3'b010);
    chk("t1_wdata", WDATA, 32'hDEAD_BEEF);
    chk("t1_wstrb", WSTRB, 4'hF);
    @(negedge ACLK);
    chk("t1_aw_dropped", AWVALID, 0);
    chk("t1_w_held", WVALID, 1);
    wait_idle("t1");

    // Blocker read keeps the channel busy while four more fill the FIFO.
    w_dly = 0; ar_dly = 0; r_dly = 6;
    exp_rd.push_back('{32'hA000_0100, RESP_OKAY, 1'b0});
    push_rd(32'h100);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rd_ready", rd_cmd_ready, 1);
      exp_rd.push_back('{rexp[i], RESP_OKAY, 1'b0});
      push_rd(32'(i * 4));
    end
    chk("t2_full_ready", rd_cmd_ready, 0);
    rd_cmd_valid = 1; rd_cmd_addr = 32'h10;
    @(negedge ACLK);
    rd_cmd_valid = 0;
    chk("t2_still_full", rd_cmd_ready, 0);
    wait_idle("t2");

    // Write and read answered by the slave in the same cycle.
    r_dly = 0;
    exp_wr.push_back('{RESP_OKAY, 1'b0});
    exp_rd.push_back('{32'hA000_0024, RESP_OKAY, 1'b0});
    wr_cmd_valid = 1; wr_cmd_addr = 32'h20; wr_cmd_data = 32'h5A5A_5A5A; wr_cmd_strb = 4'hF;
    rd_cmd_valid = 1; rd_cmd_addr = 32'h24;
    @(negedge ACLK);
    wr_cmd_valid = 0; rd_cmd_valid = 0;
    cyc = 0;
    while (!wr_rsp_valid && !rd_rsp_valid && cyc < 20) begin
      @(negedge ACLK);
      cyc++;
    end
    chk("t3_wr_pulse", wr_rsp_valid, 1);
    chk("t3_rd_pulse", rd_rsp_valid, 1);
    wait_idle("t3");

    // Hung B channel: watchdog fires 16 cycles after the pop, late B gives no second pulse.
    b_en = 0;
    exp_wr.push_back('{RESP_SLVERR, 1'b1});
    push_wr(32'h30, 32'h1122_3344, 4'hF, 3'b000);
    wait_aw("t4");
    cyc = 0;
    while (!wr_rsp_valid && cyc < 60) begin
      @(negedge ACLK);
      cyc++;
    end
    chk("t4_timeout_cycles", cyc, 16);
    repeat (24) @(negedge ACLK);
    chk("t4_bready_held", BREADY, 1);
    b_en = 1;
    wait_idle("t4");

    // DECERR read with explicit data.
    r_force = 1; r_force_data = 32'h1234; r_resp = RESP_DECERR; r_dly = 2;
    exp_rd.push_back('{32'h1234, RESP_DECERR, 1'b0});
    push_rd(32'h40);
    wait_idle("t5");
    r_force = 0; r_resp = RESP_OKAY;

    // Reset while a write is stuck in issue with two entries queued.
    aw_dly = 100; w_dly = 100;
    push_wr(32'h50, 32'h1, 4'hF, 3'b000);
    push_wr(32'h54, 32'h2, 4'hF, 3'b000);
    push_wr(32'h58, 32'h3, 4'hF, 3'b000);
    wait_aw("t6");
    chk("t6_busy", wr_busy, 1);
    #2 ARESETn = 0;
    #1;
    chk("t6_rst_awvalid", AWVALID, 0);
    chk("t6_rst_wvalid", WVALID, 0);
    chk("t6_rst_busy", wr_busy, 0);
    chk("t6_rst_ready", wr_cmd_ready, 1);
    @(negedge ACLK);
    aw_dly = 0; w_dly = 0;
    ARESETn = 1;
    repeat (20) @(negedge ACLK);
    chk("t6_post_busy", wr_busy, 0);
    chk("t6_post_awvalid", AWVALID, 0);

    chk("exp_wr_left", exp_wr.size(), 0);
    chk("exp_rd_left", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench stalled");
  end
endmodule

// File: doc/axi4_lite_master_q.md
Name: axi4_lite_master_q

Overview:
Parametrised, queued successor to the single-shot AXI4-Lite master. It accepts write and read commands on ready/valid user interfaces and buffers each direction in its own command FIFO. It issues AW and W concurrently and keeps one transaction outstanding per direction, with read and write operating independently. A per-transaction watchdog guarantees the user always receives a response, even from a hung slave. It sits between on-chip control logic (CPU bridge, config sequencer) and an AXI4-Lite interconnect.

Parameters:
ADDR_W, 32, address width of AWADDR/ARADDR and command addresses
DATA_W, 32, data width; legal values 32 or 64; strobe width is DATA_W/8
CMD_DEPTH, 4, entries per command FIFO; power of 2, at least 2
TIMEOUT, 256, cycles from issue to forced response; 0 disables the watchdog

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
wr_cmd_valid  in  1  write command valid
wr_cmd_ready  out  1  write FIFO not full
wr_cmd_addr  in  ADDR_W  write address
wr_cmd_data  in  DATA_W  write data
wr_cmd_strb  in  DATA_W/8  byte strobes
wr_cmd_prot  in  3  AWPROT value
rd_cmd_valid  in  1  read command valid
rd_cmd_ready  out  1  read FIFO not full
rd_cmd_addr  in  ADDR_W  read address
rd_cmd_prot  in  3  ARPROT value
wr_rsp_valid  out  1  one-cycle write completion pulse
wr_rsp_resp  out  2  BRESP, or SLVERR on timeout
wr_rsp_timeout  out  1  qualifies wr_rsp_valid: watchdog fired
rd_rsp_valid  out  1  one-cycle read completion pulse
rd_rsp_data  out  DATA_W  RDATA, or 0 on timeout
rd_rsp_resp  out  2  RRESP, or SLVERR on timeout
rd_rsp_timeout  out  1  qualifies rd_rsp_valid
wr_busy / rd_busy  out  1  FIFO non-empty or transaction in flight
AW*/W*/B*/AR*/R*  AXI4-Lite master signals; widths per ADDR_W/DATA_W

Behaviour:
- Reset: all AXI VALID/READY outputs 0, all *_rsp_* outputs 0, busy 0, FIFOs empty, cmd_ready 1. Reset applies immediately regardless of any in-flight transaction; no response is generated for aborted commands.
- FIFO push: on cmd_valid && cmd_ready. cmd_ready = !full. A push and pop in the same cycle while full is not allowed, because ready is already low.
- Write FSM:
  - W_IDLE: when the FIFO is non-empty, pop the head entry into the AW/W registers and go to W_ISSUE.
  - W_ISSUE: AWVALID and WVALID are both asserted from the cycle after the pop. Each is dropped independently in the cycle after its own handshake. Address and data are stable while valid. Once both have handshaken, go to W_RESP.
  - W_RESP: BREADY = 1. On BVALID, go to W_IDLE. wr_rsp_valid pulses in the next cycle with resp = BRESP.
- Read FSM:
  - R_IDLE: pop the head entry and go to R_ISSUE.
  - R_ISSUE: ARVALID until ARREADY, then go to R_RESP.
  - R_RESP: RREADY = 1. On RVALID, register RDATA/RRESP; rd_rsp_valid pulses in the next cycle.
- Back-to-back: the FSM returns to IDLE on the handshake cycle. The next issue appears 2 cycles after the previous B/R handshake.
- Watchdog, per direction, active only when TIMEOUT > 0:
  - The counter clears on pop and increments every cycle the transaction is not complete.
  - When it reaches TIMEOUT, pulse rsp_valid with resp = 2'b10, timeout = 1 and rd data = 0. Set an internal "abandoned" flag.
  - An abandoned transaction still completes legally on AXI: valids stay held and the B/R handshake is still taken. Its real response is discarded and no second pulse is produced. The FSM then returns to IDLE.
- Write data is never dropped mid-handshake; VALID is never deasserted before READY.
- Simultaneous events:
  - Read and write are fully independent; both responses may pulse in the same cycle.
  - If the timeout expiry and the B/R handshake fall in the same cycle, the real response wins and timeout = 0.
- AWPROT/ARPROT are taken from the command entry.

Decomposition:
- Package axi4_lite_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, write/read state enums, and a command struct type parametrised by width through package localparam defaults.
- Sub-module axi4_lite_cmd_fifo: synchronous FIFO parametrised in WIDTH and DEPTH, with full/empty flags. It is instantiated twice, once per direction.

Test Plan:
- Single write 0x10 <- 0xDEADBEEF, strb 0xF; slave AWREADY at +0, WREADY at +3, BRESP OKAY -> AWVALID and WVALID drop independently; one wr_rsp_valid with resp 0, timeout 0.
- Four queued reads 0x0/0x4/0x8/0xC pushed on consecutive cycles (CMD_DEPTH 4) -> cmd_ready stays 1; four rd_rsp pulses in order with matching RDATA. A fifth push in the full state sees ready 0.
- Concurrent write to 0x20 and read from 0x24, with the slave answering both in the same cycle -> wr_rsp_valid and rd_rsp_valid pulse together.
- Slave never asserts BVALID, TIMEOUT 16 -> wr_rsp_valid 16 cycles after pop with resp 2'b10 and timeout 1. A late BVALID at +40 is accepted and produces no extra pulse.
- Read returns RRESP DECERR, data 0x1234 -> rd_rsp_resp 2'b11, data 0x1234, timeout 0.
- ARESETn low while a write sits in W_ISSUE with 2 entries queued -> AWVALID/WVALID 0 immediately, FIFO empty, no response pulse after reset release.
